pe_round_collect: RTL and testbench
===================================

PE_ROUND_COLLECT -- requirements
Module: pe_round_collect

Interface
REQ-001 Parameter DEPTH, default 4, sets the FIFO entry count; legal values are powers of two from 2 to 16.
REQ-002 Parameter SYNC_STAGES, default 2, sets the synchroniser flop count on i_drive; minimum value is 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 i_drive  input  1  bundled-data request from the upstream Pe_Round stage (its o_drive); asynchronous to clk.
REQ-006 i_data  input  64  upstream round result (its o_data); held stable while i_drive is high and until o_free is returned.
REQ-007 o_free  output  1  acknowledge to the upstream stage (its i_free); a one-cycle pulse per captured word.
REQ-008 o_valid  output  1  output word available.
REQ-009 o_data  output  64  head-of-FIFO word.
REQ-010 i_ready  input  1  downstream accepts o_data when o_valid=1.
REQ-011 o_level  output  5  current FIFO occupancy, 0..DEPTH.
REQ-012 o_count  output  16  total words captured since reset, modulo 2^16.

Function
REQ-013 i_drive shall pass through SYNC_STAGES flops; a request edge is the last stage high while its registered copy is low.
REQ-014 The capture FSM shall have three states:
- IDLE: on a request edge -> PEND.
- PEND: if the FIFO has space (level<DEPTH, or a pop occurs in the same cycle) -> write i_data, pulse o_free, go to ACK; otherwise stay in PEND.
- ACK: when the synchronised i_drive is low -> IDLE.
REQ-015 o_free shall be registered and high for exactly the one cycle following the write edge.
REQ-016 With SYNC_STAGES=2 and an empty FIFO, o_valid and o_free shall go high on the 4th clk edge after the first edge that samples i_drive high (SYNC_STAGES+2 in general).
REQ-017 The FIFO shall be first-word-fall-through: o_valid=(o_level!=0), o_data=head entry, and a pop occurs when o_valid and i_ready are both high.
REQ-018 Read and write pointers shall wrap modulo DEPTH.
REQ-019 A simultaneous push and pop shall leave o_level unchanged, including when the FIFO is full.
REQ-020 A push into an empty FIFO shall not bypass: the word appears on o_data on the edge after the write.
REQ-021 A pop when o_level=0 shall be ignored.
REQ-022 No push ever occurs when full; a request instead waits in PEND with o_free low (backpressure to upstream).
REQ-023 o_count shall increment by 1 on each write and wrap 0xFFFF->0x0000.
REQ-024 The upstream stage shall hold i_drive low for at least SYNC_STAGES+1 clk periods between requests; shorter low gaps are outside the contract and may be merged.

Reset
REQ-025 Asserting rst_n low shall immediately clear the following: sync flops, the edge register, FSM (to IDLE), pointers, o_level=0, o_valid=0, o_free=0, o_count=0.
REQ-026 o_data shall be 64'h0 while o_level=0 after reset.
REQ-027 Reset mid-operation shall drop any pending or captured words.
REQ-028 If i_drive is still high after rst_n deasserts, it shall be treated as a new request and captured once.

Verification
REQ-029 Single word: i_data=64'h0123456789ABCDEF, i_drive pulse of 4 cycles, i_ready=1 -> o_free pulse on edge 4, o_valid for 1 cycle with matching o_data, o_count=1.
REQ-030 Full/backpressure: i_ready=0, send 5 words (DEPTH=4) -> o_level=4, 5th request held in PEND with no o_free; raise i_ready -> 5th captured and all 5 words drain in order.
REQ-031 Simultaneous push and pop at full: level 4, a pop and a PEND write in the same cycle -> o_level stays 4 and ordering is preserved.
REQ-032 Wrap: 20 words streamed with random i_ready -> all 20 words out in order, pointers wrap 5 times, o_count=20.
REQ-033 Reset mid-stream: level 3 with a request in PEND, pulse rst_n low -> all outputs zero immediately; i_drive still high after release -> exactly one capture.
REQ-034 Counter wrap: force 65536 captures (or preload via a bench hierarchy write) -> o_count returns to 0.

Source files
------------

// File: rtl/pe_round_collect.sv
// pe_round_collect
// ----------------
// Collects 64-bit round results from an upstream Pe_Round stage.
// The upstream stage uses a bundled-data handshake that is asynchronous to clk.
// Each captured word goes into a first-word-fall-through FIFO, which a
// valid/ready consumer drains.
//
// Ports
//   clk      : single clock; all state changes on its rising edge
//   rst_n    : asynchronous active-low reset
//   i_drive  : upstream request (asynchronous to clk)
//   i_data   : upstream word, stable while i_drive is high and until o_free
//   o_free   : one-cycle acknowledge pulse per captured word
//   o_valid  : head-of-FIFO word available
//   o_data   : head-of-FIFO word (zero while the FIFO is empty)
//   i_ready  : downstream accepts o_data
//   o_level  : FIFO occupancy, 0..DEPTH
//   o_count  : words captured since reset, modulo 2^16
//
// Handshakes
//   Downstream: a word transfers on every rising edge where o_valid and
//   i_ready are both high. o_valid never drops before that transfer. A
//   high i_ready while o_valid is low has no effect.
//   Upstream: the stage raises i_drive with i_data stable. Here the word
//   is written once, and o_free pulses for one cycle. The upstream stage
//   then lowers i_drive and keeps it low for at least SYNC_STAGES+1 cycles
//   before it makes the next request. A full FIFO holds o_free low until
//   a slot frees.

module pe_round_collect #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_drive,
    input  logic [63:0] i_data,
    output logic        o_free,
    output logic        o_valid,
    output logic [63:0] o_data,
    input  logic        i_ready,
    output logic [4:0]  o_level,
    output logic [15:0] o_count
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   drive_d;
    logic                   drive_s;
    logic                   req_edge;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [4:0]             level_q;
    logic [15:0]            count_q;
    logic                   free_q;
    logic                   push;
    logic                   pop;
    logic                   space;
    logic [63:0]            mem [DEPTH];

    // Synchroniser chain plus one extra flop for rising-edge detection.
    // Because the chain resets to zero, an i_drive that is still high when
    // reset releases shows up as a fresh request edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            drive_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_drive};
            drive_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign drive_s  = sync_q[SYNC_STAGES-1];
    assign req_edge = drive_s & ~drive_d;

    assign pop   = (level_q != 5'd0) && i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still
    // accept the pending word on that edge.
    assign space = (level_q < DEPTH_L) || pop;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_edge) state_d = PEND;
            PEND:    if (space)    state_d = ACK;
            ACK:     if (!drive_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        push = 1'b0;
        if ((state_q == PEND) && space) begin
            push = 1'b1;
        end
    end

    // FIFO storage has no reset. Reads are masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= 5'd0;
            count_q <= 16'd0;
            free_q  <= 1'b0;
        end else begin
            free_q <= push;
            if (push) begin
                wr_ptr  <= wr_ptr + PW'(1);
                count_q <= count_q + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 5'd1;
                2'b01:   level_q <= level_q - 5'd1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign o_free  = free_q;
    assign o_valid = (level_q != 5'd0);
    assign o_data  = o_valid ? mem[rd_ptr] : 64'h0;
    assign o_level = level_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_pe_round_collect.sv
// Testbench for pe_round_collect (DEPTH=4, SYNC_STAGES=2).
// Words are pushed to exp_q when requested upstream.
// They are popped and compared whenever the DUT hands a word downstream.

module tb_pe_round_collect;

    logic        clk;
    logic        rst_n;
    logic        i_drive;
    logic [63:0] i_data;
    logic        o_free;
    logic        o_valid;
    logic [63:0] o_data;
    logic        i_ready;
    logic [4:0]  o_level;
    logic [15:0] o_count;

    logic [63:0] exp_q[$];
    int          n_vec;
    int          n_err;
    int          free_cnt;
    bit          rand_ready;
    logic [63:0] held;

    pe_round_collect #(.DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_drive (i_drive),
        .i_data  (i_data),
        .o_free  (o_free),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready),
        .o_level (o_level),
        .o_count (o_count)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checks ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every downstream transfer must match the oldest request.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL spurious_word observed=%h expected=none", o_data);
            end
            if (exp_q.size() != 0) begin
                logic [63:0] e;
                e = exp_q.pop_front();
                n_vec++;
                assert (o_data === e) else begin
                    n_err++;
                    $error("FAIL scoreboard_data observed=%h expected=%h", o_data, e);
                end
            end
        end
        if (o_free) free_cnt++;
    end

    // Random downstream readiness when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_ready) i_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input logic [63:0] d);
        i_data  = d;
        i_drive = 1'b1;
        exp_q.push_back(d);
    endtask

    task automatic wait_free(input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (o_free) seen = 1'b1;
            else step();
        end
        step();
        n_vec++;
        assert (seen) else begin
            n_err++;
            $error("FAIL %s observed=no_o_free expected=o_free_within_%0d", tag, budget);
        end
    endtask

    task automatic drop();
        i_drive = 1'b0;
        repeat (5) step();
    endtask

    task automatic send(input logic [63:0] d);
        raise(d);
        wait_free(40, "send_free");
        drop();
    endtask

    task automatic wait_drain(input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (o_level == 5'd0) done = 1'b1;
            else step();
        end
        step();
        n_vec++;
        assert (done) else begin
            n_err++;
            $error("FAIL drain observed=level_%0d expected=0", o_level);
        end
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit bad;
        n_vec      = 0;
        n_err      = 0;
        free_cnt   = 0;
        rand_ready = 1'b0;
        rst_n      = 1'b0;
        i_drive    = 1'b0;
        i_ready    = 1'b1;
        i_data     = 64'h0;

        // Reset state
        repeat (3) step();
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_free",  64'(o_free),  64'd0);
        chk("rst_level", 64'(o_level), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        rst_n = 1'b1;
        step();
        step();
        chk("rst_data", o_data, 64'h0);

        // Single word, cycle exact: o_free and o_valid on edge 4
        raise(64'h0123456789ABCDEF);
        step();                       // edge 1 samples i_drive high
        step();                       // edge 2
        step();                       // edge 3
        @(negedge clk);
        chk("e3_free",  64'(o_free),  64'd0);
        chk("e3_valid", 64'(o_valid), 64'd0);
        step();                       // edge 4
        i_drive = 1'b0;
        @(negedge clk);
        chk("e4_free",  64'(o_free),  64'd1);
        chk("e4_valid", 64'(o_valid), 64'd1);
        chk("e4_data",  o_data, 64'h0123456789ABCDEF);
        step();                       // edge 5
        @(negedge clk);
        chk("e5_free",  64'(o_free),  64'd0);
        chk("e5_valid", 64'(o_valid), 64'd0);
        chk("e5_count", 64'(o_count), 64'd1);
        repeat (6) step();

        // Fill the FIFO, then hold a fifth request with backpressure
        i_ready = 1'b0;
        for (int w = 0; w < 4; w++) send(64'hA000_0000_0000_0000 | 64'(w));
        chk("full_level", 64'(o_level), 64'd4);
        raise(64'hA000_0000_0000_0004);
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (o_free) bad = 1'b1;
            step();
        end
        chk("pend_no_free", 64'(bad), 64'd0);
        chk("pend_level",   64'(o_level), 64'd4);

        // Release: pop and pending write land on the same edge at full
        i_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("full_pushpop_level", 64'(o_level), 64'd4);
        chk("full_pushpop_free",  64'(o_free),  64'd1);
        step();
        drop();
        wait_drain(60);
        chk("bp_count", 64'(o_count), 64'd6);

        // Stream 20 words with random downstream readiness
        rand_ready = 1'b1;
        for (int w = 0; w < 20; w++) send({$urandom, $urandom});
        rand_ready = 1'b0;
        i_ready    = 1'b1;
        wait_drain(60);
        chk("stream_count", 64'(o_count), 64'd26);

        // Reset mid-stream with a request in PEND
        i_ready = 1'b0;
        for (int w = 0; w < 3; w++) send(64'hC000_0000_0000_0000 | 64'(w));
        chk("pre_rst_level", 64'(o_level), 64'd3);
        held = 64'hDEAD_BEEF_0000_0003;
        raise(held);
        step();
        step();
        step();                       // FSM now in PEND
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", 64'(o_level), 64'd0);
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_free",  64'(o_free),  64'd0);
        chk("mid_rst_count", 64'(o_count), 64'd0);
        chk("mid_rst_data",  o_data, 64'h0);
        exp_q.delete();
        step();
        step();
        rst_n    = 1'b1;
        free_cnt = 0;
        exp_q.push_back(held);        // i_drive still high: one new capture
        wait_free(40, "post_rst_free");
        drop();
        repeat (10) step();
        chk("post_rst_captures", 64'(free_cnt), 64'd1);
        chk("post_rst_level",    64'(o_level),  64'd1);
        chk("post_rst_count",    64'(o_count),  64'd1);
        i_ready = 1'b1;
        wait_drain(20);

        // Counter wrap via preload
        force dut.count_q = 16'hFFFE;
        @(negedge clk);
        release dut.count_q;
        step();
        chk("preload_count", 64'(o_count), 64'hFFFE);
        send(64'h1111_2222_3333_4444);
        chk("count_ffff", 64'(o_count), 64'hFFFF);
        send(64'h5555_6666_7777_8888);
        chk("count_wrap", 64'(o_count), 64'h0000);
        wait_drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
